// File: rtl/lsu_mem_master_if.sv
// rtl/lsu_mem_master_if.sv - request/response and data_mem bus bundle for lsu_mem_master
interface lsu_mem_master_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator for data_mem with RMW sub-word stores; LSU_MISALIGN_CHECK_EN enables misalignment errors
module lsu_mem_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 256
) (
  input  logic clk,
  input  logic rst_n,
  lsu_mem_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERR} state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_WORD = ADDR_WIDTH'(MEM_BYTES - 4);

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  illegal, out_of_range, misalign, req_err;
  logic [ADDR_WIDTH-1:0] req_word_addr;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [31:0]           load_val;
  logic [31:0]           merged;
  logic                  req_ready_c, rsp_valid_c, mem_read_c, mem_write_c;

  // Classify the incoming request; only feeds the next-state decision, never the mem_* outputs
  always_comb begin
    req_word_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
    illegal       = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                    (bus.req_funct3 == 3'b111) || (bus.req_we && bus.req_funct3[2]);
    out_of_range  = req_word_addr > MAX_WORD;
`ifdef LSU_MISALIGN_CHECK_EN
    misalign      = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign      = 1'b0;
`endif
    req_err       = illegal || out_of_range || misalign;
  end

  // Lane extraction for loads and lane replacement for SB/SH, both from the word read back in CAP
  always_comb begin
    lane_b = bus.mem_rdata[7:0];
    case (addr_q[1:0])
      2'b00: lane_b = bus.mem_rdata[7:0];
      2'b01: lane_b = bus.mem_rdata[15:8];
      2'b10: lane_b = bus.mem_rdata[23:16];
      2'b11: lane_b = bus.mem_rdata[31:24];
      default: lane_b = bus.mem_rdata[7:0];
    endcase
    // Half accesses select by addr[1] only, so addr[0] is ignored when unchecked
    lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_val = funct3_q[2] ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = funct3_q[2] ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = bus.mem_rdata;
    endcase

    merged = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (addr_q[1:0])
        2'b00: merged[7:0]   = wdata_q[7:0];
        2'b01: merged[15:8]  = wdata_q[7:0];
        2'b10: merged[23:16] = wdata_q[7:0];
        2'b11: merged[31:24] = wdata_q[7:0];
        default: merged = bus.mem_rdata;
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (req_err)
            state_d = ERR;
          else if (bus.req_we && (bus.req_funct3 == 3'b010))
            state_d = WR;
          else
            state_d = RD;
        end
      end
      RD: begin
        mem_read_c = 1'b1;
        state_d    = CAP;
      end
      CAP: begin
        if (we_q) begin
          wdata_d = merged;
          state_d = WR;
        end else begin
          rsp_valid_c = 1'b1;
          rdata_d     = load_val;
          state_d     = IDLE;
        end
      end
      WR: begin
        mem_write_c = 1'b1;
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        rsp_valid_c = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Handshake and strobes are killed while reset is low so an interrupted RMW never writes
  assign bus.req_ready = rst_n && req_ready_c;
  assign bus.rsp_valid = rst_n && rsp_valid_c;
  assign bus.mem_read  = rst_n && mem_read_c;
  assign bus.mem_write = rst_n && mem_write_c;
  assign bus.rsp_err   = rst_n && (state_q == ERR);
  assign bus.rsp_rdata = ((state_q == CAP) && !we_q) ? load_val : rdata_q;
  assign bus.mem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master with data_mem and reference model
module tb_lsu_mem_master;

  logic clk;
  logic rst_n;
  lsu_mem_master_if #(.ADDR_WIDTH(32)) bus ();

  lsu_mem_master #(.ADDR_WIDTH(32), .MEM_BYTES(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] dmem [0:255];
  logic [7:0] rmem [0:255];

  // model expectation for the transaction in flight
  logic        pending = 1'b0;
  int          cyc = 0;
  logic        m_we, m_err, m_rd, m_wr;
  int          m_lat;
  int          m_al;
  logic [31:0] m_ld, m_wword;
  logic [31:0] hold = 32'b0;
  logic [31:0] cap_rdata, cap_wword;
  logic        cap_err;
  int          n_rd, n_wr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // data_mem: registered read, whole-word write at the clock edge
  always @(posedge clk) begin
    int a;
    a = int'(bus.mem_addr & 32'h0000_00FC);
    if (bus.mem_read)
      bus.mem_rdata <= {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
    if (bus.mem_write) begin
      dmem[a]   = bus.mem_wdata[7:0];
      dmem[a+1] = bus.mem_wdata[15:8];
      dmem[a+2] = bus.mem_wdata[23:16];
      dmem[a+3] = bus.mem_wdata[31:24];
    end
  end

  function automatic logic [31:0] rword(input int al);
    return {rmem[al+3], rmem[al+2], rmem[al+1], rmem[al]};
  endfunction

  // Reference: work out error, latency, load value and written word from the ISA rules
  task automatic prep(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic       illegal, oor, mis;
    logic [7:0] b [4];
    int         hb;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd3);
    oor     = (addr & 32'hFFFF_FFFC) > 32'd252;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) || (f3 == 3'd2 && (addr % 4 != 0));
`else
    mis = 1'b0;
`endif
    m_we  = we;
    m_err = illegal || oor || mis;
    m_al  = int'(addr & 32'h0000_00FC);
    if (m_err)                  m_lat = 1;
    else if (we && f3 == 3'd2)  m_lat = 1;
    else if (we)                m_lat = 3;
    else                        m_lat = 2;
    m_rd = !m_err && !(we && f3 == 3'd2);
    m_wr = we && !m_err;
    m_ld = 32'b0;
    m_wword = 32'b0;
    if (!m_err) begin
      hb = m_al + ((addr % 4 >= 2) ? 2 : 0);
      case (f3)
        3'd0: m_ld = {{24{rmem[addr % 256][7]}}, rmem[addr % 256]};
        3'd4: m_ld = {24'b0, rmem[addr % 256]};
        3'd1: m_ld = {{16{rmem[hb+1][7]}}, rmem[hb+1], rmem[hb]};
        3'd5: m_ld = {16'b0, rmem[hb+1], rmem[hb]};
        default: m_ld = rword(m_al);
      endcase
      for (int k = 0; k < 4; k++) b[k] = rmem[m_al+k];
      if (f3 == 3'd0) b[addr % 4] = wdata[7:0];
      else if (f3 == 3'd1) begin b[hb-m_al] = wdata[7:0]; b[hb-m_al+1] = wdata[15:8]; end
      else for (int k = 0; k < 4; k++) b[k] = wdata[8*k +: 8];
      m_wword = {b[3], b[2], b[1], b[0]};
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    prep(we, f3, addr, wdata);
    @(negedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n_rd = 0;
    n_wr = 0;
    cyc = 0;
    pending = 1'b1;
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 12 && pending; k++) begin
      @(negedge clk);
      #1;
    end
    if (pending) begin
      check("rsp_timeout", 32'd1, 32'd0);
      pending = 1'b0;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    issue(we, f3, addr, wdata);
    wait_rsp();
  endtask

  // Compare process: every cycle, outputs against the model
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      hold = 32'b0;
      check("reset_strobes", {27'b0, bus.req_ready, bus.rsp_valid, bus.mem_read, bus.mem_write, bus.rsp_err}, 32'b0);
    end else if (!pending) begin
      check("idle_strobes", {28'b0, bus.req_ready, bus.rsp_valid, bus.mem_read, bus.mem_write}, 32'h8);
      check("rdata_hold", bus.rsp_rdata, hold);
    end else begin
      cyc++;
      if (bus.mem_read) n_rd++;
      if (bus.mem_write) begin n_wr++; cap_wword = bus.mem_wdata; end
      check("req_ready_busy", {31'b0, bus.req_ready}, 32'b0);
      check("mem_read", {31'b0, bus.mem_read}, {31'b0, m_rd && cyc == 1});
      check("mem_write", {31'b0, bus.mem_write}, {31'b0, m_wr && cyc == m_lat});
      if (m_rd && cyc == 1) check("rd_addr", bus.mem_addr, m_al);
      if (m_wr && cyc == m_lat) begin
        check("wr_addr", bus.mem_addr, m_al);
        check("wr_data", bus.mem_wdata, m_wword);
      end
      check("rsp_valid", {31'b0, bus.rsp_valid}, {31'b0, cyc == m_lat});
      if (cyc == m_lat) begin
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, m_err});
        if (!m_we && !m_err) hold = m_ld;
        check("rsp_rdata", bus.rsp_rdata, hold);
        cap_rdata = bus.rsp_rdata;
        cap_err = bus.rsp_err;
        if (m_wr)
          for (int k = 0; k < 4; k++) rmem[m_al+k] = m_wword[8*k +: 8];
        pending = 1'b0;
      end
    end
  end

  initial begin
    int diffs;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr = 32'b0;
    bus.req_wdata = 32'b0;
    bus.mem_rdata = 32'b0;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'(i * 7 + 3);
      rmem[i] = 8'(i * 7 + 3);
    end
    dmem[16] = 8'h44; dmem[17] = 8'h33; dmem[18] = 8'h22; dmem[19] = 8'h11;
    rmem[16] = 8'h44; rmem[17] = 8'h33; rmem[18] = 8'h22; rmem[19] = 8'h11;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {bus.rsp_rdata | bus.mem_addr | bus.mem_wdata}, 32'b0);
    check("rst_ready", {31'b0, bus.req_ready}, 32'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", {31'b0, bus.req_ready}, 32'd1);

    // word load
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_10", cap_rdata, 32'h11223344);
    check("lw_10_reads", n_rd, 32'd1);
    check("lw_10_writes", n_wr, 32'd0);

    // sign/zero extension
    do_req(1'b1, 3'd0, 32'h13, 32'h80);
    do_req(1'b0, 3'd0, 32'h13, 32'h0);
    check("lb_13", cap_rdata, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h13, 32'h0);
    check("lbu_13", cap_rdata, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h12, 32'h0);
    check("lh_12", cap_rdata, 32'hFFFF8022);
    do_req(1'b1, 3'd0, 32'h13, 32'h11);

    // byte RMW
    do_req(1'b1, 3'd0, 32'h12, 32'hFFFFFFAB);
    check("sb_wword", cap_wword, 32'h11AB3344);
    check("sb_reads", n_rd, 32'd1);
    check("sb_writes", n_wr, 32'd1);
    check("sb_rdata_held", cap_rdata, 32'hFFFF8022);
    do_req(1'b0, 3'd2, 32'h10, 32'h0);
    check("lw_after_sb", cap_rdata, 32'h11AB3344);

    // misaligned and out-of-range
    do_req(1'b0, 3'd2, 32'h11, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    check("lw_11_err", {31'b0, cap_err}, 32'd1);
    check("lw_11_reads", n_rd, 32'd0);
`else
    check("lw_11_err", {31'b0, cap_err}, 32'd0);
    check("lw_11", cap_rdata, 32'h11AB3344);
`endif
    do_req(1'b0, 3'd2, 32'h100, 32'h0);
    check("lw_100_err", {31'b0, cap_err}, 32'd1);
    check("lw_100_reads", n_rd, 32'd0);

    // illegal funct3 and the last in-range word
    do_req(1'b0, 3'd3, 32'h10, 32'h0);
    check("ld_f3_011_err", {31'b0, cap_err}, 32'd1);
    do_req(1'b1, 3'd4, 32'h10, 32'h0);
    check("st_f3_100_err", {31'b0, cap_err}, 32'd1);
    do_req(1'b1, 3'd2, 32'hFC, 32'hDEADBEEF);
    check("sw_fc_writes", n_wr, 32'd1);
    do_req(1'b0, 3'd2, 32'hFC, 32'h0);
    check("lw_fc", cap_rdata, 32'hDEADBEEF);
    do_req(1'b0, 3'd5, 32'hFE, 32'h0);
    check("lhu_fe", cap_rdata, 32'h0000DEAD);
    do_req(1'b0, 3'd1, 32'hFE, 32'h0);
    check("lh_fe", cap_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 3'd0, 32'hFF, 32'h0);
    check("lb_ff", cap_rdata, 32'hFFFFFFDE);
    do_req(1'b1, 3'd1, 32'h32, 32'h1234);
    do_req(1'b0, 3'd2, 32'h30, 32'h0);
    do_req(1'b1, 3'd1, 32'h21, 32'h5A5A);
    do_req(1'b0, 3'd2, 32'hFD, 32'h0);

    // reset during the CAP cycle of an SH
    issue(1'b1, 3'd1, 32'h20, 32'h5555);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("sh_aborted_mem", {dmem[35], dmem[34], dmem[33], dmem[32]}, rword(32));
    do_req(1'b0, 3'd2, 32'h20, 32'h0);

    diffs = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== rmem[i]) diffs++;
    check("mem_image", diffs, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
